// File: rtl/bram_sfifo_asym.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bram_sfifo_asym : single-clock BRAM FIFO, 1:1/1:2/1:4/2:1/4:1 width ratio,
//                   occupancy-counted flags, sticky errors, optional FWFT.
// Revision: 1.0
// ----------------------------------------------------------------------------
module bram_sfifo_asym #(
  parameter int DATA_WIDTH0 = 18,
  parameter int DATA_WIDTH1 = 18,
  parameter int ADDR_WIDTH0 = 10,
  parameter int UPAF        = 10,
  parameter int UPAE        = 10,
  parameter int FWFT        = 0
) (
  input  logic                   clock0,
  input  logic                   Sync_Flush,
  input  logic                   PUSH,
  input  logic [DATA_WIDTH0-1:0] DIN,
  input  logic                   POP,
  output logic [DATA_WIDTH1-1:0] DOUT,
  output logic                   Full,
  output logic                   Almost_Full,
  output logic                   Full_Watermark,
  output logic                   Empty,
  output logic                   Almost_Empty,
  output logic                   Empty_Watermark,
  output logic                   Overrun_Error,
  output logic                   Underrun_Error
);

  localparam int U    = (DATA_WIDTH0 < DATA_WIDTH1) ? DATA_WIDTH0 : DATA_WIDTH1;
  localparam int WMAX = (DATA_WIDTH0 < DATA_WIDTH1) ? DATA_WIDTH1 : DATA_WIDTH0;
  localparam int R    = WMAX / U;
  localparam int LR   = (R == 4) ? 2 : ((R == 2) ? 1 : 0);
  localparam int WU   = DATA_WIDTH0 / U;
  localparam int RU   = DATA_WIDTH1 / U;
  localparam int LWU  = (DATA_WIDTH0 > DATA_WIDTH1) ? LR : 0;
  localparam int LRU  = (DATA_WIDTH1 > DATA_WIDTH0) ? LR : 0;
  localparam int UAW  = ADDR_WIDTH0 + LWU;
  localparam int CW   = UAW + 1;
  localparam int MAW  = UAW - LR;

  localparam logic [CW-1:0] C_DEPTH_U = {1'b1, {UAW{1'b0}}};
  localparam logic [CW-1:0] C_WU      = CW'(WU);
  localparam logic [CW-1:0] C_RU      = CW'(RU);
  localparam logic [31:0]   C_UPAF    = 32'(UPAF);
  localparam logic [31:0]   C_UPAE    = 32'(UPAE);
  localparam bit            C_FWM_RST = (64'(UPAF) >= (64'(1) << ADDR_WIDTH0));

  generate
    if ((WMAX % U) != 0 || (R != 1 && R != 2 && R != 4)) begin : g_bad_ratio
      $error("bram_sfifo_asym: width ratio must be 1, 2 or 4");
    end
  endgenerate

  logic [UAW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   ov_q, ov_d;
  logic                   full_q, full_d, afull_q, afull_d, fwm_q, fwm_d;
  logic                   empty_q, empty_d, aempty_q, aempty_d, ewm_q, ewm_d;
  logic                   ovr_q, ovr_d, udr_q, udr_d;
  logic [DATA_WIDTH1-1:0] dout_q;
  logic                   push_ok, pop_ok, rd_en;
  logic [CW-1:0]          mem_units, free_words, avail_words, vis_words;

  always_comb begin
    push_ok   = PUSH & ~full_q;
    pop_ok    = POP & ~empty_q;
    // In FWFT mode the output register holds one read word outside the RAM.
    mem_units = count_q - (ov_q ? C_RU : '0);
    if (FWFT != 0) begin
      rd_en = (~ov_q | pop_ok) & (mem_units >= C_RU);
      ov_d  = rd_en | (ov_q & ~pop_ok);
    end else begin
      rd_en = pop_ok;
      ov_d  = 1'b0;
    end
    count_d     = count_q + (push_ok ? C_WU : '0) - (pop_ok ? C_RU : '0);
    wptr_d      = push_ok ? wptr_q + UAW'(WU) : wptr_q;
    rptr_d      = rd_en ? rptr_q + UAW'(RU) : rptr_q;
    free_words  = (C_DEPTH_U - count_d) >> LWU;
    avail_words = count_d >> LRU;
    vis_words   = ((FWFT != 0) && !ov_d) ? '0 : avail_words;
    full_d      = (free_words == '0);
    afull_d     = (free_words == CW'(1));
    fwm_d       = (32'(free_words) <= C_UPAF);
    empty_d     = (vis_words == '0);
    aempty_d    = (vis_words == CW'(1));
    ewm_d       = (32'(vis_words) <= C_UPAE);
    ovr_d       = ovr_q | (PUSH & full_q);
    udr_d       = udr_q | (POP & empty_q);
  end

  always_ff @(posedge clock0) begin
    if (Sync_Flush) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      ov_q     <= 1'b0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      fwm_q    <= C_FWM_RST;
      empty_q  <= 1'b1;
      aempty_q <= 1'b0;
      ewm_q    <= 1'b1;
      ovr_q    <= 1'b0;
      udr_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      ov_q     <= ov_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      fwm_q    <= fwm_d;
      empty_q  <= empty_d;
      aempty_q <= aempty_d;
      ewm_q    <= ewm_d;
      ovr_q    <= ovr_d;
      udr_q    <= udr_d;
    end
  end

  // RAM words are WMAX wide; the narrow side addresses a U-wide slice of one word.
  generate
    if (DATA_WIDTH0 >= DATA_WIDTH1) begin : g_wr_wide
      logic [WMAX-1:0] mem [2**MAW];
      logic [MAW-1:0]  waddr, raddr;
      logic [1:0]      rsel;

      assign waddr = MAW'(wptr_q >> LR);
      assign raddr = MAW'(rptr_q >> LR);
      assign rsel  = 2'(rptr_q & UAW'(R - 1));

      always_ff @(posedge clock0) begin
        if (push_ok && !Sync_Flush) mem[waddr] <= DIN;
      end

      always_ff @(posedge clock0) begin
        if (Sync_Flush)  dout_q <= '0;
        else if (rd_en)  dout_q <= mem[raddr][int'(rsel)*U +: U];
      end
    end else begin : g_rd_wide
      logic [WMAX-1:0] mem [2**MAW];
      logic [MAW-1:0]  waddr, raddr;
      logic [1:0]      wsel;

      assign waddr = MAW'(wptr_q >> LR);
      assign raddr = MAW'(rptr_q >> LR);
      assign wsel  = 2'(wptr_q & UAW'(R - 1));

      always_ff @(posedge clock0) begin
        if (push_ok && !Sync_Flush) mem[waddr][int'(wsel)*U +: U] <= DIN;
      end

      always_ff @(posedge clock0) begin
        if (Sync_Flush)  dout_q <= '0;
        else if (rd_en)  dout_q <= mem[raddr];
      end
    end
  endgenerate

  assign DOUT            = dout_q;
  assign Full            = full_q;
  assign Almost_Full     = afull_q;
  assign Full_Watermark  = fwm_q;
  assign Empty           = empty_q;
  assign Almost_Empty    = aempty_q;
  assign Empty_Watermark = ewm_q;
  assign Overrun_Error   = ovr_q;
  assign Underrun_Error  = udr_q;

endmodule
`default_nettype wire

// File: tb/tb_bram_sfifo_asym.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_bram_sfifo_asym : directed self-checking bench for bram_sfifo_asym.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_bram_sfifo_asym;

  logic clk;
  logic flush;

  // Flag vectors: {Full, Almost_Full, Full_Watermark, Empty, Almost_Empty,
  //                Empty_Watermark, Overrun_Error, Underrun_Error}
  logic        a_push, a_pop;
  logic [17:0] a_din, a_dout;
  logic [7:0]  a_fl;
  logic        b_push, b_pop;
  logic [35:0] b_din;
  logic [8:0]  b_dout;
  logic [7:0]  b_fl;
  logic        c_push, c_pop;
  logic [8:0]  c_din;
  logic [35:0] c_dout;
  logic [7:0]  c_fl;
  logic        d_push, d_pop;
  logic [17:0] d_din, d_dout;
  logic [7:0]  d_fl;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bram_sfifo_asym #(.DATA_WIDTH0(18), .DATA_WIDTH1(18), .ADDR_WIDTH0(10),
                    .UPAF(10), .UPAE(10), .FWFT(0)) u_a (
    .clock0(clk), .Sync_Flush(flush), .PUSH(a_push), .DIN(a_din), .POP(a_pop),
    .DOUT(a_dout), .Full(a_fl[7]), .Almost_Full(a_fl[6]), .Full_Watermark(a_fl[5]),
    .Empty(a_fl[4]), .Almost_Empty(a_fl[3]), .Empty_Watermark(a_fl[2]),
    .Overrun_Error(a_fl[1]), .Underrun_Error(a_fl[0]));

  bram_sfifo_asym #(.DATA_WIDTH0(36), .DATA_WIDTH1(9), .ADDR_WIDTH0(9),
                    .UPAF(10), .UPAE(10), .FWFT(0)) u_b (
    .clock0(clk), .Sync_Flush(flush), .PUSH(b_push), .DIN(b_din), .POP(b_pop),
    .DOUT(b_dout), .Full(b_fl[7]), .Almost_Full(b_fl[6]), .Full_Watermark(b_fl[5]),
    .Empty(b_fl[4]), .Almost_Empty(b_fl[3]), .Empty_Watermark(b_fl[2]),
    .Overrun_Error(b_fl[1]), .Underrun_Error(b_fl[0]));

  bram_sfifo_asym #(.DATA_WIDTH0(9), .DATA_WIDTH1(36), .ADDR_WIDTH0(11),
                    .UPAF(10), .UPAE(10), .FWFT(0)) u_c (
    .clock0(clk), .Sync_Flush(flush), .PUSH(c_push), .DIN(c_din), .POP(c_pop),
    .DOUT(c_dout), .Full(c_fl[7]), .Almost_Full(c_fl[6]), .Full_Watermark(c_fl[5]),
    .Empty(c_fl[4]), .Almost_Empty(c_fl[3]), .Empty_Watermark(c_fl[2]),
    .Overrun_Error(c_fl[1]), .Underrun_Error(c_fl[0]));

  bram_sfifo_asym #(.DATA_WIDTH0(18), .DATA_WIDTH1(18), .ADDR_WIDTH0(10),
                    .UPAF(10), .UPAE(10), .FWFT(1)) u_d (
    .clock0(clk), .Sync_Flush(flush), .PUSH(d_push), .DIN(d_din), .POP(d_pop),
    .DOUT(d_dout), .Full(d_fl[7]), .Almost_Full(d_fl[6]), .Full_Watermark(d_fl[5]),
    .Empty(d_fl[4]), .Almost_Empty(d_fl[3]), .Empty_Watermark(d_fl[2]),
    .Overrun_Error(d_fl[1]), .Underrun_Error(d_fl[0]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] fill_word(input int a);
    logic [31:0] t;
    t = 32'(a) | (32'(a) << 20) | 32'h55000;
    return t[17:0];
  endfunction

  function automatic logic [17:0] stream_word(input int t);
    return 18'(32'h1000 + 32'(t) * 3);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    flush  = 1'b1;
    a_push = 1'b0; a_pop = 1'b0; a_din = '0;
    b_push = 1'b0; b_pop = 1'b0; b_din = '0;
    c_push = 1'b0; c_pop = 1'b0; c_din = '0;
    d_push = 1'b0; d_pop = 1'b0; d_din = '0;

    // Reset state
    tick();
    tick();
    flush = 1'b0;
    chk("rst_a_flags", 64'(a_fl), 64'h14);
    chk("rst_a_dout",  64'(a_dout), 64'h0);
    chk("rst_b_flags", 64'(b_fl), 64'h14);
    chk("rst_c_flags", 64'(c_fl), 64'h14);
    chk("rst_d_flags", 64'(d_fl), 64'h14);
    chk("rst_d_dout",  64'(d_dout), 64'h0);

    // Fill 18/18 registered-read FIFO
    a_push = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      a_din = fill_word(i);
      tick();
      if (i == 0)    chk("fill_first_flags", 64'(a_fl), 64'h0C);
      if (i == 1012) chk("fill_1013_flags",  64'(a_fl), 64'h00);
      if (i == 1013) chk("fill_1014_flags",  64'(a_fl), 64'h20);
      if (i == 1022) chk("fill_1023_flags",  64'(a_fl), 64'h60);
    end
    chk("full_flags", 64'(a_fl), 64'hA0);
    a_din = 18'h3FFFF;
    tick();
    chk("overrun_flags", 64'(a_fl), 64'hA2);
    a_push = 1'b0;

    // Drain
    a_pop = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      tick();
      chk("drain_dout", 64'(a_dout), 64'(fill_word(i)));
      if (i == 1022) chk("drain_one_left_flags", 64'(a_fl), 64'h0E);
    end
    chk("drained_flags", 64'(a_fl), 64'h16);
    tick();
    chk("underrun_flags", 64'(a_fl), 64'h17);
    chk("dout_hold",      64'(a_dout), 64'(fill_word(1023)));
    a_pop = 1'b0;

    // 36 -> 9
    b_push = 1'b1;
    b_din  = 36'h123456789;
    tick();
    b_push = 1'b0;
    chk("b_push_flags", 64'(b_fl), 64'h04);
    b_pop = 1'b1;
    tick();
    chk("b_pop0", 64'(b_dout), 64'h189);
    chk("b_pop0_flags", 64'(b_fl), 64'h04);
    tick();
    chk("b_pop1", 64'(b_dout), 64'h0B3);
    tick();
    chk("b_pop2", 64'(b_dout), 64'h0D1);
    chk("b_ae_flags", 64'(b_fl), 64'h0C);
    tick();
    chk("b_pop3", 64'(b_dout), 64'h024);
    chk("b_empty_flags", 64'(b_fl), 64'h14);
    b_pop = 1'b0;

    // 9 -> 36
    c_push = 1'b1;
    c_din = 9'h189; tick(); chk("c_part1_flags", 64'(c_fl), 64'h14);
    c_din = 9'h0B3; tick(); chk("c_part2_flags", 64'(c_fl), 64'h14);
    c_din = 9'h0D1; tick(); chk("c_part3_flags", 64'(c_fl), 64'h14);
    c_din = 9'h024; tick(); chk("c_word_flags",  64'(c_fl), 64'h0C);
    c_push = 1'b0;
    c_pop  = 1'b1;
    tick();
    c_pop = 1'b0;
    chk("c_pop_dout",  64'(c_dout), 64'h123456789);
    chk("c_pop_flags", 64'(c_fl), 64'h14);

    // FWFT single word
    d_push = 1'b1;
    d_din  = 18'h00AAA;
    tick();
    d_push = 1'b0;
    chk("fwft_k_flags", 64'(d_fl), 64'h14);
    chk("fwft_k_dout",  64'(d_dout), 64'h0);
    tick();
    chk("fwft_k1_flags", 64'(d_fl), 64'h0C);
    chk("fwft_k1_dout",  64'(d_dout), 64'h00AAA);
    d_pop = 1'b1;
    tick();
    d_pop = 1'b0;
    chk("fwft_popped_flags", 64'(d_fl), 64'h14);
    chk("fwft_popped_hold",  64'(d_dout), 64'h00AAA);

    // FWFT streaming push+pop
    for (int t = 0; t <= 101; t++) begin
      d_push = (t < 100);
      d_din  = stream_word(t);
      d_pop  = (t >= 2);
      tick();
      if (t >= 1 && t <= 100) begin
        chk("stream_dout",  64'(d_dout), 64'(stream_word(t - 1)));
        chk("stream_empty", 64'(d_fl[4]), 64'h0);
      end
    end
    d_push = 1'b0;
    d_pop  = 1'b0;
    chk("stream_end_flags", 64'(d_fl), 64'h14);

    // Simultaneous push/pop at Full, then flush with PUSH held
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("reflush_flags", 64'(a_fl), 64'h14);
    a_push = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      a_din = fill_word(i);
      tick();
    end
    chk("refill_full_flags", 64'(a_fl), 64'hA0);
    a_pop = 1'b1;
    a_din = 18'h3FFFF;
    tick();
    a_push = 1'b0;
    a_pop  = 1'b0;
    chk("simul_flags", 64'(a_fl), 64'h62);
    chk("simul_dout",  64'(a_dout), 64'(fill_word(0)));
    flush  = 1'b1;
    a_push = 1'b1;
    a_din  = 18'h12345;
    tick();
    flush  = 1'b0;
    a_push = 1'b0;
    chk("flush_flags", 64'(a_fl), 64'h14);
    chk("flush_dout",  64'(a_dout), 64'h0);
    tick();
    chk("post_flush_flags", 64'(a_fl), 64'h14);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
